// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_pkg
//  Purpose  : Shared constants, state encoding and header-length helper for
//             the instruction-memory loader.
//  Contents : DEPTH   - words in the target instruction memory
//             ADDR_W  - memory address width (log2 DEPTH)
//             IDX_W   - width of the byte-within-word index
//             state_t - loader state encoding
//             len_ok  - header-length range test
//  Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int IDX_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // A header is acceptable only when it names between one and depth words;
    // zero and anything past the end of memory are both rejected.
    function automatic logic len_ok(input logic [31:0] n, input int depth);
        return (n != 32'd0) && (n <= 32'(depth));
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_if
//  Purpose  : Bundles the loader's control, byte-stream, memory-write and
//             status signals.
//  Ports    : start, in_valid, in_data       - driven by the master
//             in_ready                        - byte-stream back-pressure
//             mem_we, mem_addr, mem_wdata     - instruction-memory write port
//             busy, done, err                 - status flags
//             word_count, checksum            - load progress / integrity
//  Modports : master - stream source / observer
//             slave  - the loader itself
//  Revision : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_W = imem_pkg::ADDR_W
) ();
    import imem_pkg::*;

    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       checksum;

    modport master (
        output start,
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  busy,
        input  done,
        input  err,
        input  word_count,
        input  checksum
    );

    modport slave (
        input  start,
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output busy,
        output done,
        output err,
        output word_count,
        output checksum
    );

endinterface
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : word_assembler
//  Purpose  : Collects accepted bytes into little-endian 32-bit words. The
//             first three bytes of a word are held in a shift register; the
//             fourth byte is combined on the fly so the complete word is
//             presented in the same cycle that byte is accepted.
//  Ports    : clk        - clock, rising edge
//             reset      - synchronous, active-low reset
//             clear      - synchronous restart of the byte index
//             byte_en    - a byte is accepted this cycle
//             byte_in    - the accepted byte
//             word       - assembled word (meaningful when word_valid)
//             word_valid - one-cycle pulse on acceptance of the fourth byte
//  Revision : 1.0 - initial release
// ============================================================================
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);
    import imem_pkg::*;

    logic [IDX_W-1:0] byte_idx;
    // New bytes enter at the top and move down, so after three bytes the
    // first one sits in [7:0] and the third in [23:16].
    logic [23:0]      shreg;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            byte_idx <= '0;
            shreg    <= '0;
        end else if (byte_en) begin
            // The index wraps from 3 back to 0, starting the next word.
            byte_idx <= byte_idx + IDX_W'(1);
            shreg    <= {byte_in, shreg[23:8]};
        end
    end

    assign word       = {byte_in, shreg};
    assign word_valid = byte_en && (byte_idx == '1);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Loads an instruction memory from a byte stream. The stream
//             begins with a 32-bit little-endian length word N, followed by
//             N little-endian program words written to addresses 0..N-1.
//             A running XOR checksum and word count are kept for the host.
//  Ports    : clk   - clock, rising edge
//             reset - synchronous, active-low reset
//             bus   - imem_loader_if.slave: start, byte stream (in_valid,
//                     in_data, in_ready), memory write (mem_we, mem_addr,
//                     mem_wdata), status (busy, done, err, word_count,
//                     checksum)
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH  = imem_pkg::DEPTH,
    parameter int ADDR_W = imem_pkg::ADDR_W
) (
    input  logic           clk,
    input  logic           reset,
    imem_loader_if.slave   bus
);
    import imem_pkg::*;

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            state_q;
    state_t            state_d;

    logic              in_ready;
    logic              accept;
    logic              restart;
    logic              word_valid;
    logic [31:0]       word;
    logic              hdr_ok;
    logic              last_word;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [ADDR_W:0]   word_count_q;
    logic [31:0]       checksum_q;
    logic [ADDR_W:0]   len_q;

    // Bytes are only taken while a load is in progress; DONE and ERR
    // refuse the stream until the host restarts.
    assign in_ready = (state_q == ST_HDR) || (state_q == ST_LOAD);
    assign accept   = bus.in_valid && in_ready;

    // start is honoured only from a resting state, so a stray pulse during
    // a load cannot corrupt it.
    assign restart  = bus.start &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                       (state_q == ST_ERR));

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_en    (accept),
        .byte_in    (bus.in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign hdr_ok    = len_ok(word, DEPTH);
    // word_count is the index of the word being completed, so the final
    // word is the one that brings the count up to the header length.
    assign last_word = (word_count_q + CNT_ONE) == len_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (word_valid) begin
                    state_d = hdr_ok ? ST_LOAD : ST_ERR;
                end
            end
            ST_LOAD: begin
                if (word_valid && last_word) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The write of a completed word is registered, so it appears in the
    // cycle after its fourth byte; for the last word that is the first DONE
    // cycle. Count and checksum update on the same edge as the strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
            checksum_q   <= '0;
            len_q        <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (restart) begin
                word_count_q <= '0;
                checksum_q   <= '0;
            end
            if ((state_q == ST_HDR) && word_valid && hdr_ok) begin
                len_q <= word[ADDR_W:0];
            end
            if ((state_q == ST_LOAD) && word_valid) begin
                mem_we_q     <= 1'b1;
                mem_addr_q   <= word_count_q[ADDR_W-1:0];
                mem_wdata_q  <= word;
                word_count_q <= word_count_q + CNT_ONE;
                checksum_q   <= checksum_q ^ word;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.word_count = word_count_q;
    assign bus.checksum   = checksum_q;
    assign bus.busy       = (state_q == ST_HDR) || (state_q == ST_LOAD);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.err        = (state_q == ST_ERR);

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words in the target instruction memory.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning the memory address width (log2 DEPTH).
REQ-003 The block SHALL have port clk  input  1  clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 The block SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 The block SHALL have port in_data  input  8  byte-stream data.
REQ-008 The block SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both high at a rising edge.
REQ-009 The block SHALL have port mem_we  output  1  one-cycle write strobe to the instruction memory.
REQ-010 The block SHALL have port mem_addr  output  ADDR_W  write word address.
REQ-011 The block SHALL have port mem_wdata  output  32  write data.
REQ-012 The block SHALL have ports busy, done and err  output  1 each  status flags.
REQ-013 The block SHALL have port word_count  output  ADDR_W+1  number of words written.
REQ-014 The block SHALL have port checksum  output  32  XOR of all words written.

Function
REQ-015 States SHALL be IDLE, HDR, LOAD, DONE and ERR.
REQ-016 In IDLE, DONE or ERR, start=1 SHALL move the block to HDR and clear word_count, checksum, done, err and the byte index.
REQ-017 start SHALL be ignored in HDR and LOAD.
REQ-018 in_ready SHALL be 1 only in HDR and LOAD.
REQ-019 Words SHALL be assembled little-endian: the first accepted byte is bits [7:0], the fourth is bits [31:24].
REQ-020 In HDR, the first assembled word SHALL be the length N; N in 1..DEPTH SHALL go to LOAD, any other value SHALL go to ERR.
REQ-021 In LOAD, each completed word k (0-based) SHALL produce mem_we=1 for exactly one cycle, in the cycle after its fourth byte is accepted, with mem_addr=k and mem_wdata=word.
REQ-022 word_count SHALL increment and checksum SHALL XOR in the word in the same cycle that mem_we is asserted.
REQ-023 The edge that accepts the fourth byte of word N-1 SHALL move the block to DONE; that word's mem_we SHALL occur in the first DONE cycle.
REQ-024 Gaps in in_valid SHALL stall assembly without producing writes, and back-to-back bytes SHALL be accepted every cycle.
REQ-025 mem_addr SHALL never wrap: N=DEPTH ends at address DEPTH-1 with word_count=DEPTH.
REQ-026 busy SHALL be 1 in HDR and LOAD, done SHALL be 1 in DONE, err SHALL be 1 in ERR, and all three SHALL be 0 in IDLE.
REQ-027 No bytes SHALL be accepted in ERR or DONE, and no write SHALL occur in ERR.

Reset
REQ-028 With reset=0 at a rising edge, the block SHALL enter IDLE with in_ready, mem_we, busy, done and err at 0, and mem_addr, mem_wdata, word_count, checksum and the byte index at 0.
REQ-029 A reset during HDR or LOAD SHALL discard any partial word, SHALL suppress any pending mem_we, and SHALL let the next load restart at address 0.

Structure
REQ-030 Package imem_pkg SHALL hold DEPTH, ADDR_W and the state enum type.
REQ-031 Sub-module word_assembler (byte shift register plus 2-bit byte index, word_valid pulse) SHALL be instantiated once.

Verification
REQ-032 Stimulus: start; header 03 00 00 00; bytes 01 00 00 f8, 02 80 00 f8, 03 02 00 f8. Required response: writes addr 0/1/2 = f8000001/f8008002/f8000203, done=1, word_count=3, checksum=f8008200.
REQ-033 Stimulus: same stream as REQ-032 with 1-3 idle cycles between bytes. Required response: identical writes, exactly 3 mem_we pulses.
REQ-034 Stimulus: header 00000000, then header 00000041. Required response: err=1, in_ready=0, no mem_we in each case.
REQ-035 Stimulus: header 00000040 with 64 words. Required response: last write at addr 63, word_count=64, done=1.
REQ-036 Stimulus: reset low after 2 bytes of word 1, then a new load of 1 word. Required response: no write for the partial word, and the new word written at addr 0.
REQ-037 Stimulus: start pulsed mid-LOAD. Required response: ignored, and the load completes normally.
